ram2p_clr: RTL and testbench
============================

// Module: ram2p_clr
// PURPOSE
//   Single-clock true dual-port RAM with byte-lane write enables and explicit read strobes/valids.
//   Read latency is configurable (1 or 2 cycles). Write-collision handling is defined, and a
//   hardware clear engine fills the array with CLR_VAL after reset or on request.
//   Used as shared scratch/buffer memory between two masters in one clock domain.
// PARAMETERS
//   DEPTH    256  number of words; DEPTH <= 2**AWID
//   AWID     8    address width
//   DWID     16   data width; must be a multiple of BWID
//   BWID     8    byte-lane width; NBE = DWID/BWID lanes (localparam)
//   RD_LAT   1    read latency in cycles, 1 or 2 (2 adds an output register)
//   RDW_MODE 0    same-port read-during-write: 0 = old data (read-first), 1 = new data (write-first)
//   CLR_VAL  0    DWID-bit fill value written by the clear engine
// PORTS
//   clk          in   1     clock, rising edge
//   rst_n        in   1     asynchronous reset, active low
//   clr_start    in   1     pulse: start clear of whole array (ignored while busy)
//   busy         out  1     clear engine running; both ports stalled
//   coll         out  1     1-cycle pulse: both ports wrote the same address
//   porta__re    in   1     port A read strobe
//   porta__we    in   1     port A write strobe
//   porta__be    in   NBE   port A byte-lane enables (qualify we)
//   porta__addr  in   AWID  port A address
//   porta__din   in   DWID  port A write data
//   porta__dout  out  DWID  port A read data
//   porta__rvld  out  1     port A read data valid
//   portb__*     --   --    same set as port A, for port B
// BEHAVIOUR
//   Reset (rst_n=0, async): dout=0, rvld=0, coll=0, busy=1, clear address=0.
//     Array contents are not reset.
//   Clear FSM, states CLEAR/IDLE:
//     - On rst_n release: CLEAR.
//     - In CLEAR, write CLR_VAL to address 0,1,..,DEPTH-1, one per cycle.
//     - After the last address: IDLE, busy=0 (busy high for exactly DEPTH cycles).
//     - IDLE & clr_start: CLEAR from address 0.
//     - Reset during CLEAR restarts the clear from address 0 after release.
//   While busy: re/we on both ports are ignored, rvld=0, dout holds its value.
//   Write (we=1 & !busy): lane i of mem[addr] <= din lane i when be[i]=1.
//     we with be=0 writes nothing.
//   Read (re=1 & !busy):
//     - rvld=1 exactly RD_LAT cycles after the re cycle, with dout = data at that address.
//     - dout holds its last value when rvld=0.
//     - Back-to-back reads give one result per cycle.
//   Same-port re & we, same cycle: RDW_MODE=0 returns the pre-write word;
//     RDW_MODE=1 returns the merged word (new lanes where be=1, old lanes elsewhere).
//   Cross-port read of an address the other port writes in the same cycle: always the pre-write word.
//   Both ports we to the same address:
//     - Lanes enabled by A take A data; lanes enabled only by B take B data.
//     - coll=1 in the next cycle, even if the be masks do not overlap.
//   addr >= DEPTH: write discarded; read returns 0 with rvld asserted normally.
//   Pipeline: with RD_LAT=2, a read issued in the cycle clr_start is accepted still completes.
// TESTING
//   1. Reset, release -> busy=1 for DEPTH (256) cycles, then 0. Read all addresses -> 0x0000, rvld at latency 1.
//   2. A writes 0xBEEF at 0x10 with be=2'b01, then reads 0x10 -> 0x00EF.
//      B writes 0x12xx at 0x10 with be=2'b10, A reads -> 0x12EF.
//   3. A and B both write 0x20 (A=0xAAAA be=11, B=0x5555 be=11) -> mem=0xAAAA, coll pulses once next cycle.
//      Repeat with A be=01, B be=10 -> 0x55AA, coll=1.
//   4. RDW_MODE=0 and RDW_MODE=1: A re+we 0x1234 at an address holding 0xFFFF -> dout 0xFFFF and 0x1234 respectively.
//   5. RD_LAT=2: reads on 4 consecutive cycles at addresses 0..3 -> rvld high on cycles 2..5, data in order.
//      Read at addr >= DEPTH (DEPTH=200) -> 0.
//   6. Assert rst_n low mid-clear at address 100 -> outputs 0, busy=1.
//      After release -> clear restarts, busy low after 256 cycles. clr_start while busy -> no extra cycles.

Source files
------------

// File: rtl/ram2p_clr.sv
// ram2p_clr: dual-port byte-lane RAM with read valids, 1/2-cycle latency, collision flag and clear engine
// Ports: clk, rst_n (async, active low), clr_start (start fill), busy (fill running),
//   coll (both ports wrote one address last cycle), porta__*/portb__* re/we/be/addr/din/dout/rvld
module ram2p_clr #(
  parameter int DEPTH = 256,
  parameter int AWID = 8,
  parameter int DWID = 16,
  parameter int BWID = 8,
  parameter int RD_LAT = 1,
  parameter int RDW_MODE = 0,
  parameter logic [DWID-1:0] CLR_VAL = '0,
  localparam int NBE = DWID / BWID
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_start,
  output logic            busy,
  output logic            coll,
  input  logic            porta__re,
  input  logic            porta__we,
  input  logic [NBE-1:0]  porta__be,
  input  logic [AWID-1:0] porta__addr,
  input  logic [DWID-1:0] porta__din,
  output logic [DWID-1:0] porta__dout,
  output logic            porta__rvld,
  input  logic            portb__re,
  input  logic            portb__we,
  input  logic [NBE-1:0]  portb__be,
  input  logic [AWID-1:0] portb__addr,
  input  logic [DWID-1:0] portb__din,
  output logic [DWID-1:0] portb__dout,
  output logic            portb__rvld
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_CLEAR = 1'b1;
  logic                       r_state;
  logic [AWID-1:0]            r_caddr;
  logic                       r_coll;
  logic [DWID-1:0]            r_mem [DEPTH];
  logic [1:0]                 r_v1;
  logic [1:0][DWID-1:0]       r_d1;
  logic                       w_busy;
  logic [1:0]                 w_re, w_we, w_ok, w_wr, w_rd, w_v;
  logic [1:0][NBE-1:0]        w_be;
  logic [1:0][AWID-1:0]       w_addr;
  logic [1:0][DWID-1:0]       w_din, w_old, w_mrg, w_rdata, w_d;
  assign w_busy = r_state == S_CLEAR;
  assign w_re = {portb__re, porta__re};
  assign w_we = {portb__we, porta__we};
  assign w_be = {portb__be, porta__be};
  assign w_addr = {portb__addr, porta__addr};
  assign w_din = {portb__din, porta__din};
  assign w_wr = w_we & w_ok & {2{!w_busy}};
  assign w_rd = w_re & {2{!w_busy}};
  // old word comes from the array before this edge's writes, so cross-port reads always see pre-write data
  always_comb begin
    w_ok = '0;
    w_old = '0;
    w_mrg = '0;
    for (int p = 0; p < 2; p++) begin
      w_ok[p] = 32'(w_addr[p]) < DEPTH;
      w_old[p] = w_ok[p] ? r_mem[w_addr[p]] : '0;
      w_mrg[p] = w_old[p];
      for (int i = 0; i < NBE; i++)
        if (w_wr[p] && w_be[p][i]) w_mrg[p][i*BWID +: BWID] = w_din[p][i*BWID +: BWID];
    end
  end
  assign w_rdata = (RDW_MODE == 1) ? w_mrg : w_old;
  // port B is written first so port A wins any lane both ports enable
  always_ff @(posedge clk) begin
    if (w_busy) r_mem[r_caddr] <= CLR_VAL;
    else
      for (int p = 1; p >= 0; p--)
        if (w_wr[p])
          for (int i = 0; i < NBE; i++)
            if (w_be[p][i]) r_mem[w_addr[p]][i*BWID +: BWID] <= w_din[p][i*BWID +: BWID];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_caddr <= '0;
      r_coll <= 1'b0;
    end else begin
      r_coll <= &w_wr && (w_addr[0] == w_addr[1]);
      r_state <= w_busy ? ((r_caddr == AWID'(DEPTH - 1)) ? S_IDLE : S_CLEAR) : (clr_start ? S_CLEAR : S_IDLE);
      r_caddr <= w_busy ? r_caddr + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= '0;
      r_d1 <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_v1[p] <= w_rd[p];
        if (w_rd[p]) r_d1[p] <= w_rdata[p];
      end
    end
  end
  // second stage advances regardless of busy so a read accepted alongside clr_start still completes
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [1:0]           r_v2;
      logic [1:0][DWID-1:0] r_d2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= '0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          for (int p = 0; p < 2; p++)
            if (r_v1[p]) r_d2[p] <= r_d1[p];
        end
      end
      assign w_v = r_v2;
      assign w_d = r_d2;
    end else begin : g_lat1
      assign w_v = r_v1;
      assign w_d = r_d1;
    end
  endgenerate
  assign busy = w_busy;
  assign coll = r_coll;
  assign porta__dout = w_d[0];
  assign portb__dout = w_d[1];
  assign porta__rvld = w_v[0];
  assign portb__rvld = w_v[1];
endmodule

// File: tb/tb_ram2p_clr.sv
// tb_ram2p_clr: scoreboard bench for ram2p_clr (u0: lat1/read-first/256 words, u1: lat2/write-first/200 words, fill 0xFFFF)
module tb_ram2p_clr;
  typedef struct packed {
    logic [15:0] d;
    logic [31:0] due;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, clr_start = 1'b0;
  logic a_re = 0, a_we = 0, b_re = 0, b_we = 0;
  logic [1:0] a_be = 0, b_be = 0;
  logic [7:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_din = 0, b_din = 0;
  logic busy0, coll0, a0_v, b0_v, busy1, coll1, a1_v, b1_v;
  logic [15:0] a0_d, b0_d, a1_d, b1_d;
  int checks = 0, failures = 0, cyc = 0, n0, n1;
  exp_t qa0[$], qb0[$], qa1[$], qb1[$];
  ram2p_clr u0 (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy0), .coll(coll0),
    .porta__re(a_re), .porta__we(a_we), .porta__be(a_be), .porta__addr(a_addr), .porta__din(a_din),
    .porta__dout(a0_d), .porta__rvld(a0_v),
    .portb__re(b_re), .portb__we(b_we), .portb__be(b_be), .portb__addr(b_addr), .portb__din(b_din),
    .portb__dout(b0_d), .portb__rvld(b0_v));
  ram2p_clr #(.DEPTH(200), .RD_LAT(2), .RDW_MODE(1), .CLR_VAL(16'hFFFF)) u1 (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy1), .coll(coll1),
    .porta__re(a_re), .porta__we(a_we), .porta__be(a_be), .porta__addr(a_addr), .porta__din(a_din),
    .porta__dout(a1_d), .porta__rvld(a1_v),
    .portb__re(b_re), .portb__we(b_we), .portb__be(b_be), .portb__addr(b_addr), .portb__din(b_din),
    .portb__dout(b1_d), .portb__rvld(b1_v));
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", n, act, req);
    end
  endfunction
  function automatic void got(string n, logic [15:0] d, exp_t e);
    chk({n, "_data"}, 32'(d), 32'(e.d));
    chk({n, "_lat"}, cyc, e.due);
  endfunction
  function automatic void extra(string n);
    checks++;
    failures++;
    $display("FAIL %s_unexpected_rvld act=1 req=0", n);
  endfunction
  always @(negedge clk) begin
    if (a0_v) begin if (qa0.size() == 0) extra("a0"); else got("a0", a0_d, qa0.pop_front()); end
    if (b0_v) begin if (qb0.size() == 0) extra("b0"); else got("b0", b0_d, qb0.pop_front()); end
    if (a1_v) begin if (qa1.size() == 0) extra("a1"); else got("a1", a1_d, qa1.pop_front()); end
    if (b1_v) begin if (qb1.size() == 0) extra("b1"); else got("b1", b1_d, qb1.pop_front()); end
  end
  task automatic step;
    @(posedge clk);
    #1;
    {a_re, a_we, b_re, b_we, clr_start} = '0;
    {a_be, b_be} = '0;
  endtask
  task automatic rd_a(logic [7:0] ad, logic [15:0] e0, logic [15:0] e1);
    a_re = 1; a_addr = ad;
    qa0.push_back(exp_t'{e0, 32'(cyc + 1)});
    qa1.push_back(exp_t'{e1, 32'(cyc + 2)});
  endtask
  task automatic rd_b(logic [7:0] ad, logic [15:0] e0, logic [15:0] e1);
    b_re = 1; b_addr = ad;
    qb0.push_back(exp_t'{e0, 32'(cyc + 1)});
    qb1.push_back(exp_t'{e1, 32'(cyc + 2)});
  endtask
  task automatic wr_a(logic [7:0] ad, logic [15:0] d, logic [1:0] be);
    a_we = 1; a_addr = ad; a_din = d; a_be = be;
  endtask
  task automatic wr_b(logic [7:0] ad, logic [15:0] d, logic [1:0] be);
    b_we = 1; b_addr = ad; b_din = d; b_be = be;
  endtask
  task automatic count_busy(input bit inj, output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy0 && !busy1) break;
      c0 += int'(busy0); c1 += int'(busy1);
      if (inj && k == 50) begin clr_start = 1; a_re = 1; a_we = 1; a_be = 2'b11; a_addr = 8'h30; a_din = 16'h1111; end
      if (inj && k == 51) begin clr_start = 0; a_re = 0; a_we = 0; a_be = 0; end
    end
  endtask
  task automatic chk_reset(string n);
    chk({n, "_dout"}, {a0_d, b0_d}, 32'h0);
    chk({n, "_dout_l2"}, {a1_d, b1_d}, 32'h0);
    chk({n, "_rvld"}, {28'h0, a0_v, b0_v, a1_v, b1_v}, 32'h0);
    chk({n, "_busy_coll"}, {28'h0, busy0, busy1, coll0, coll1}, 32'hC);
  endtask
  initial begin
    #1 rst_n = 0;
    #2 chk_reset("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    count_busy(0, n0, n1);
    chk("init_busy_cycles_256", n0, 256);
    chk("init_busy_cycles_200", n1, 200);
    step;
    for (int i = 0; i < 256; i++) begin
      rd_a(8'(i), 16'h0, (i < 200) ? 16'hFFFF : 16'h0);
      if (i < 4) rd_b(8'(i), 16'h0, 16'hFFFF);
      step;
    end
    wr_a(8'h10, 16'hBEEF, 2'b01); step;
    rd_a(8'h10, 16'h00EF, 16'hFFEF); step;
    wr_b(8'h10, 16'h1234, 2'b10); step;
    @(negedge clk) chk("coll_single_write", {coll0, coll1}, 0);
    rd_a(8'h10, 16'h12EF, 16'h12EF); step;
    wr_a(8'h20, 16'hAAAA, 2'b11); wr_b(8'h20, 16'h5555, 2'b11); step;
    @(negedge clk) chk("coll_full_pulse", {coll0, coll1}, 2'b11);
    step;
    @(negedge clk) chk("coll_full_drop", {coll0, coll1}, 2'b00);
    rd_a(8'h20, 16'hAAAA, 16'hAAAA); step;
    wr_a(8'h20, 16'hAAAA, 2'b01); wr_b(8'h20, 16'h5555, 2'b10); step;
    @(negedge clk) chk("coll_disjoint_be", {coll0, coll1}, 2'b11);
    rd_a(8'h20, 16'h55AA, 16'h55AA); step;
    wr_a(8'h30, 16'hFFFF, 2'b11); step;
    rd_a(8'h30, 16'hFFFF, 16'h1234); wr_a(8'h30, 16'h1234, 2'b11); step;
    rd_a(8'h30, 16'h1234, 16'h5634); wr_a(8'h30, 16'h5600, 2'b10); step;
    wr_a(8'h30, 16'h9999, 2'b11); rd_b(8'h30, 16'h5634, 16'h5634); step;
    rd_b(8'h30, 16'h9999, 16'h9999); step;
    for (int i = 0; i < 4; i++) begin wr_a(8'(i), 16'h1000 + 16'(i), 2'b11); step; end
    for (int i = 0; i < 4; i++) begin rd_a(8'(i), 16'h1000 + 16'(i), 16'h1000 + 16'(i)); step; end
    wr_a(8'd210, 16'h7777, 2'b11); step;
    rd_a(8'd210, 16'h7777, 16'h0000); rd_b(8'd199, 16'h0, 16'hFFFF); step;
    repeat (3) step;
    rd_a(8'h30, 16'h9999, 16'h9999); clr_start = 1; step;
    count_busy(1, n0, n1);
    chk("clr_busy_cycles_256", n0, 256);
    chk("clr_busy_cycles_200", n1, 200);
    step;
    rd_a(8'h30, 16'h0, 16'hFFFF); rd_b(8'h10, 16'h0, 16'hFFFF); step;
    wr_a(8'h05, 16'hABCD, 2'b11); step;
    rd_a(8'h05, 16'hABCD, 16'hABCD); step;
    repeat (3) step;
    clr_start = 1; step;
    repeat (100) @(posedge clk);
    #2 rst_n = 0;
    #1 chk_reset("midclr_reset");
    @(posedge clk);
    #2 rst_n = 1;
    count_busy(0, n0, n1);
    chk("restart_busy_cycles_256", n0, 256);
    chk("restart_busy_cycles_200", n1, 200);
    repeat (4) step;
    chk("queues_drained", qa0.size() + qb0.size() + qa1.size() + qb1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
